bin_to_bcd_dd: RTL and testbench
================================

Name: bin_to_bcd_dd

Overview:
Parametrised sequential binary-to-BCD converter using the double-dabble (shift-and-add-3) algorithm. It processes one bit per clock, with all digits adjusted in parallel, and uses a start/busy/valid handshake. It sits between datapath counters/ADC readouts and the seven-segment display driver, and generalises the fixed 12-bit/4-digit converter. Adds configurable width and digit count, overflow detection, reset, and optional signed input.

Parameters:
BIN_W, 12, binary input width in bits (2..32).
DIGITS, 4, number of BCD output digits (1..10); fewer than needed for 2^BIN_W-1 is legal and raises ovf on overrange values.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  request conversion of bin_in; sampled only in IDLE.
bin_in  input  BIN_W  binary operand, captured on the accepting edge.
busy  output  1  high whenever state is not IDLE.
valid  output  1  one-cycle pulse when bcd_out/ovf/neg are updated.
bcd_out  output  4*DIGITS  packed BCD result, digit 0 in bits [3:0]; held until next completion.
ovf  output  1  result exceeded DIGITS decimal digits; held with bcd_out.
neg  output  1  sign of result (only with BIN2BCD_SIGNED_EN; constant 0 otherwise).

Behaviour:
- Reset: one clock; reset is asynchronous and active-high. Asserting rst forces state=IDLE, busy=0, valid=0, bcd_out=0, ovf=0, neg=0, and clears the shift register and bit counter immediately, independent of clk.
- Reset mid-conversion aborts the conversion with no valid pulse. The first start after rst deasserts is accepted normally.
- States: IDLE -> CONV -> DONE -> IDLE. No other encodings are reachable; any illegal encoding returns to IDLE.
- IDLE: busy=0. If start=1 at an edge, the block loads the working register {DIGITS*4 zeros, bin_in}, sets bit counter=BIN_W-1, clears the sticky overflow flag, and goes to CONV.
- CONV: each cycle, every digit >4 gets +3, then the whole register shifts left by 1. If the bit shifted out of the top digit is 1, the sticky overflow flag is set. When counter==0 the state goes to DONE; otherwise the counter decrements.
- DONE: bcd_out <= digit field, ovf <= sticky flag, neg <= captured sign, valid=1 for this cycle only. Next state is IDLE.
- Latency: start accepted at edge N gives valid high in the cycle after edge N+BIN_W+1, i.e. BIN_W+1 cycles after acceptance. With start held high, throughput is one conversion every BIN_W+2 cycles.
- start while busy (CONV or DONE) is ignored; it is not queued. A bin_in change after acceptance has no effect.
- On ovf=1, bcd_out holds the low DIGITS digits of the true decimal value (modulo 10^DIGITS). Each digit is still always a valid BCD code 0..9.
- Width rules: the working register is 4*DIGITS+BIN_W bits. The bit counter is clog2(BIN_W) bits wide.

Optional Feature:
BIN2BCD_SIGNED_EN. When defined, bin_in is two's complement. At acceptance, neg <= bin_in[BIN_W-1] (registered, presented at DONE) and the loaded magnitude is |bin_in|. -2^(BIN_W-1) yields magnitude 2^(BIN_W-1) with no error. When undefined, bin_in is unsigned, neg is tied 0, and no negation logic is built.

Decomposition:
- Shared header bin2bcd_defs.vh holds the state encodings (IDLE=2'd0, CONV=2'd1, DONE=2'd2), DIGIT_W=4, and the adjust threshold constant 4 / adjust value 3.
- One sub-module, bcd_digit_adj: combinational 4-bit in/out, outputs d+3 when d>4, else d.
- Instantiate DIGITS copies of bcd_digit_adj via a generate loop.

Test Plan:
- Defaults, bin_in=4095, start 1 cycle -> busy next cycle; valid exactly 13 cycles after acceptance; bcd_out=16'h4095, ovf=0.
- bin_in=0 and bin_in=1 -> bcd_out=16'h0000 then 16'h0001, one valid pulse each.
- Pulse start again 3 cycles after acceptance with bin_in=7 -> ignored; result from the original operand; single valid.
- DIGITS=3, bin_in=1000 -> bcd_out=12'h000, ovf=1. Then bin_in=999 -> 12'h999, ovf=0 (flag cleared per conversion).
- Assert rst asynchronously (between edges) at cycle 5 of CONV -> outputs zero immediately, no valid pulse. Next start with 250 -> 16'h0250.
- BIN2BCD_SIGNED_EN defined, bin_in=12'h800 -> bcd_out=16'h2048, neg=1. bin_in=12'hFFF -> 16'h0001, neg=1. bin_in=12'h7FF -> 16'h2047, neg=0.

Source files
------------

// File: rtl/bin_to_bcd_dd_pkg.sv
// Shared constants for the double-dabble binary-to-BCD converter:
// state encodings, digit width and the shift-and-add-3 adjust constants.
package bin_to_bcd_dd_pkg;

    localparam int DIGIT_W = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CONV = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // A digit above this threshold would exceed 9 after the next doubling
    localparam logic [DIGIT_W-1:0] ADJ_THRESH = 4'd4;
    localparam logic [DIGIT_W-1:0] ADJ_VAL    = 4'd3;

endpackage

// File: rtl/bin_to_bcd_dd_digit_adj.sv
// Single-digit double-dabble correction: adds 3 to a BCD digit greater than 4
// so that the following left shift carries correctly into the next digit.
module bcd_digit_adj
    import bin_to_bcd_dd_pkg::*;
(
    input  logic [DIGIT_W-1:0] d,
    output logic [DIGIT_W-1:0] q
);

    assign q = (d > ADJ_THRESH) ? d + ADJ_VAL : d;

endmodule

// File: rtl/bin_to_bcd_dd.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock).
// Define BIN2BCD_SIGNED_EN to treat bin_in as two's complement and report the sign on neg.
module bin_to_bcd_dd
    import bin_to_bcd_dd_pkg::*;
#(
    parameter int BIN_W  = 12,
    parameter int DIGITS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [BIN_W-1:0]          bin_in,
    output logic                      busy,
    output logic                      valid,
    output logic [DIGIT_W*DIGITS-1:0] bcd_out,
    output logic                      ovf,
    output logic                      neg
);

    localparam int BCD_W = DIGIT_W * DIGITS;
    localparam int REG_W = BCD_W + BIN_W;
    localparam int CNT_W = $clog2(BIN_W);

    logic [1:0]       state_q;
    logic [REG_W-1:0] work_q;
    logic [REG_W-1:0] adj;
    logic [CNT_W-1:0] cnt_q;
    logic             ovf_sticky_q;
    logic [BCD_W-1:0] bcd_q;
    logic             ovf_q;
    logic             valid_q;
    logic [BIN_W-1:0] load_mag;

`ifdef BIN2BCD_SIGNED_EN
    logic signed [BIN_W-1:0] bin_s;
    logic                    sign_q;
    logic                    neg_q;

    // Most-negative input wraps to itself, which read unsigned is the correct magnitude
    assign bin_s    = bin_in;
    assign load_mag = bin_s[BIN_W-1] ? $unsigned(-bin_s) : $unsigned(bin_s);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sign_q <= 1'b0;
            neg_q  <= 1'b0;
        end else begin
            if (state_q == ST_IDLE && start)
                sign_q <= bin_s[BIN_W-1];
            if (state_q == ST_DONE)
                neg_q <= sign_q;
        end
    end

    assign neg = neg_q;
`else
    assign load_mag = bin_in;
    assign neg      = 1'b0;
`endif

    // Binary field passes straight through; every digit field is adjusted in parallel
    assign adj[BIN_W-1:0] = work_q[BIN_W-1:0];

    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
        bcd_digit_adj u_adj (
            .d(work_q[BIN_W+DIGIT_W*i +: DIGIT_W]),
            .q(adj[BIN_W+DIGIT_W*i +: DIGIT_W])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            work_q       <= '0;
            cnt_q        <= '0;
            ovf_sticky_q <= 1'b0;
            bcd_q        <= '0;
            ovf_q        <= 1'b0;
            valid_q      <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        work_q       <= {{BCD_W{1'b0}}, load_mag};
                        cnt_q        <= CNT_W'(BIN_W - 1);
                        ovf_sticky_q <= 1'b0;
                        state_q      <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    work_q <= {adj[REG_W-2:0], 1'b0};
                    // A set bit leaving the top digit is a lost 10^DIGITS carry
                    if (adj[REG_W-1])
                        ovf_sticky_q <= 1'b1;
                    if (cnt_q == '0)
                        state_q <= ST_DONE;
                    else
                        cnt_q <= cnt_q - CNT_W'(1);
                end
                ST_DONE: begin
                    bcd_q   <= work_q[REG_W-1 -: BCD_W];
                    ovf_q   <= ovf_sticky_q;
                    valid_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy    = (state_q != ST_IDLE);
    assign valid   = valid_q;
    assign bcd_out = bcd_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_dd.sv
// Scoreboard bench for bin_to_bcd_dd: a default 4-digit instance and a 3-digit
// instance, checked against a decimal reference model with exact latency.
module tb_bin_to_bcd_dd;

    localparam int BIN_W = 12;
    localparam int DIG_A = 4;
    localparam int DIG_B = 3;
    localparam int LAT   = BIN_W + 1;

    typedef struct {
        logic [39:0] bcd;
        logic        ovf;
        logic        neg;
        int          due;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst;
    logic               start_a = 1'b0, start_b = 1'b0;
    logic [BIN_W-1:0]   bin_a = '0, bin_b = '0;
    logic               busy_a, busy_b, valid_a, valid_b;
    logic               ovf_a, ovf_b, neg_a, neg_b;
    logic [4*DIG_A-1:0] bcd_a;
    logic [4*DIG_B-1:0] bcd_b;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    exp_t        q_a[$];
    exp_t        q_b[$];
    logic [39:0] last_a = '0;
    logic [39:0] last_b = '0;

    bin_to_bcd_dd #(.BIN_W(BIN_W), .DIGITS(DIG_A)) u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .bin_in(bin_a),
        .busy(busy_a), .valid(valid_a), .bcd_out(bcd_a), .ovf(ovf_a), .neg(neg_a)
    );

    bin_to_bcd_dd #(.BIN_W(BIN_W), .DIGITS(DIG_B)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .bin_in(bin_b),
        .busy(busy_b), .valid(valid_b), .bcd_out(bcd_b), .ovf(ovf_b), .neg(neg_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model(input logic [BIN_W-1:0] v, input int digits, input int due);
        exp_t   e;
        longint val, mag, lim;
`ifdef BIN2BCD_SIGNED_EN
        val = longint'($signed(v));
`else
        val = longint'(v);
`endif
        e.neg = (val < 0);
        mag   = (val < 0) ? -val : val;
        lim   = 1;
        for (int i = 0; i < digits; i++) lim = lim * 10;
        e.ovf = (mag >= lim);
        e.bcd = '0;
        for (int i = 0; i < digits; i++) begin
            e.bcd[4*i +: 4] = 4'(mag % 10);
            mag = mag / 10;
        end
        e.due = due;
        return e;
    endfunction

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin : mon_a
        exp_t e;
        if (!rst) begin
            if (valid_a) begin
                if (q_a.size() == 0) begin
                    chk("a_unexpected_valid", 40'd1, 40'd0);
                end else begin
                    e = q_a.pop_front();
                    chk("a_bcd", 40'(bcd_a), e.bcd);
                    chk("a_ovf", 40'(ovf_a), 40'(e.ovf));
                    chk("a_neg", 40'(neg_a), 40'(e.neg));
                    chk("a_latency", 40'(cyc), 40'(e.due));
                    last_a = e.bcd;
                end
            end else begin
                chk("a_hold", 40'(bcd_a), last_a);
            end
        end
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        if (!rst) begin
            if (valid_b) begin
                if (q_b.size() == 0) begin
                    chk("b_unexpected_valid", 40'd1, 40'd0);
                end else begin
                    e = q_b.pop_front();
                    chk("b_bcd", 40'(bcd_b), e.bcd);
                    chk("b_ovf", 40'(ovf_b), 40'(e.ovf));
                    chk("b_neg", 40'(neg_b), 40'(e.neg));
                    chk("b_latency", 40'(cyc), 40'(e.due));
                    last_b = e.bcd;
                end
            end else begin
                chk("b_hold", 40'(bcd_b), last_b);
            end
        end
    end

    // Called just after a falling edge; waits for idle, presents one start pulse
    task automatic issue(input int which, input logic [BIN_W-1:0] v);
        int budget;
        budget = 0;
        while ((which == 0 ? busy_a : busy_b) && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 100) begin
            chk("wait_idle_timeout", 40'd1, 40'd0);
            return;
        end
        if (which == 0) begin
            start_a = 1'b1; bin_a = v;
            q_a.push_back(model(v, DIG_A, cyc + 1 + LAT));
        end else begin
            start_b = 1'b1; bin_b = v;
            q_b.push_back(model(v, DIG_B, cyc + 1 + LAT));
        end
        @(negedge clk);
        if (which == 0) begin
            start_a = 1'b0; bin_a = BIN_W'($urandom);
            chk("a_busy_after_start", 40'(busy_a), 40'd1);
        end else begin
            start_b = 1'b0; bin_b = BIN_W'($urandom);
            chk("b_busy_after_start", 40'(busy_b), 40'd1);
        end
    endtask

    task automatic check_reset_outputs();
        chk("rst_busy", 40'(busy_a), 40'd0);
        chk("rst_valid", 40'(valid_a), 40'd0);
        chk("rst_bcd", 40'(bcd_a), 40'd0);
        chk("rst_ovf", 40'(ovf_a), 40'd0);
        chk("rst_neg", 40'(neg_a), 40'd0);
    endtask

    initial begin
        int budget;
        rst = 1'b0;
        #1 rst = 1'b1;
        #1 check_reset_outputs();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        issue(0, 12'd4095);
        issue(0, 12'd0);
        issue(0, 12'd1);

        // A start pulse during conversion must be ignored
        issue(0, 12'd1234);
        @(negedge clk);
        @(negedge clk);
        start_a = 1'b1; bin_a = 12'd7;
        @(negedge clk);
        start_a = 1'b0;

        issue(1, 12'd1000);
        issue(1, 12'd999);
        issue(0, 12'h800);
        issue(0, 12'hFFF);
        issue(0, 12'h7FF);

        // Abort a conversion with an asynchronous reset between clock edges
        issue(0, 12'd3210);
        budget = 0;
        while (busy_b && budget < 100) begin @(negedge clk); budget++; end
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1 check_reset_outputs();
        q_a.delete();
        last_a = '0;
        last_b = '0;
        @(negedge clk);
        rst = 1'b0;
        issue(0, 12'd250);

        for (int i = 0; i < 40; i++) issue(0, BIN_W'($urandom));
        for (int i = 0; i < 20; i++) issue(1, BIN_W'($urandom_range(0, 4095)));

        budget = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        chk("drain_a", 40'(q_a.size()), 40'd0);
        chk("drain_b", 40'(q_b.size()), 40'd0);
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
